// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer for the IF/ID register: PC, in-order imem requests, fetch queue.
// Define IF_PERF_CNT_EN to add the perf_bubble_cnt output (IF/ID bubble counter).
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          FQ_DEPTH  = 2,
    parameter int          MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        ifid_write,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst_if,
    output logic [63:0] pcadd4_if,
    output logic        inst_valid_if
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_bubble_cnt
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int CW  = $clog2(FQ_DEPTH + MAX_OUTST + 1) + 1;
    localparam int QAW = $clog2(FQ_DEPTH);
    localparam int TAW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [63:0]    pc_q, pc_d;
    logic [CW-1:0]  outst_q, outst_d;
    logic [CW-1:0]  drop_q, drop_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [QAW-1:0] qhd_q, qhd_d;
    logic [QAW-1:0] qtl_q, qtl_d;
    logic [31:0]    qdat_q [FQ_DEPTH];
    logic [31:0]    qdat_d [FQ_DEPTH];
    logic [63:0]    qpc_q  [FQ_DEPTH];
    logic [63:0]    qpc_d  [FQ_DEPTH];
    logic [63:0]    tag_q  [MAX_OUTST];
    logic [63:0]    tag_d  [MAX_OUTST];
    logic [TAW-1:0] thd_q, thd_d;
    logic [TAW-1:0] ttl_q, ttl_d;

    logic fire;
    logic push;
    logic pop;
    logic [CW-1:0] fire_w;
    logic [CW-1:0] rsp_w;
    logic [CW-1:0] push_w;
    logic [CW-1:0] pop_w;
    logic unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];

    function automatic logic [TAW-1:0] tinc(input logic [TAW-1:0] p);
        return (p == TAW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit counts in-flight requests against free queue slots, so a
    // returning word always has room and the response side never stalls.
    assign imem_req_valid = !rst && !redirect_valid && drop_q == '0
                            && (outst_q + cnt_q) < CW'(FQ_DEPTH)
                            && outst_q < CW'(MAX_OUTST);
    assign imem_req_addr  = pc_q;

    assign fire = imem_req_valid && imem_req_ready;
    assign push = imem_rsp_valid && drop_q == '0 && !redirect_valid;
    assign pop  = ifid_write && inst_valid_if && !redirect_valid;

    assign fire_w = {{(CW-1){1'b0}}, fire};
    assign rsp_w  = {{(CW-1){1'b0}}, imem_rsp_valid};
    assign push_w = {{(CW-1){1'b0}}, push};
    assign pop_w  = {{(CW-1){1'b0}}, pop};

    assign inst_valid_if = cnt_q != '0;
    assign inst_if       = inst_valid_if ? qdat_q[qhd_q] : NOP;
    assign pcadd4_if     = inst_valid_if ? qpc_q[qhd_q] : 64'h0;

    always_comb begin
        pc_d    = pc_q;
        outst_d = outst_q + fire_w - rsp_w;
        drop_d  = drop_q;
        cnt_d   = cnt_q;
        qhd_d   = qhd_q;
        qtl_d   = qtl_q;
        qdat_d  = qdat_q;
        qpc_d   = qpc_q;
        tag_d   = tag_q;
        thd_d   = thd_q;
        ttl_d   = ttl_q;

        if (fire) begin
            pc_d         = pc_q + 64'd4;
            tag_d[ttl_q] = pc_q + 64'd4;
            ttl_d        = tinc(ttl_q);
        end
        // Dropped responses still pop their tag, keeping tags aligned
        // with the in-order response stream across redirects.
        if (imem_rsp_valid) begin
            thd_d = tinc(thd_q);
        end

        if (redirect_valid) begin
            pc_d   = {redirect_pc[63:2], 2'b00};
            drop_d = outst_d;
            cnt_d  = '0;
            qhd_d  = '0;
            qtl_d  = '0;
        end else begin
            if (imem_rsp_valid && drop_q != '0) begin
                drop_d = drop_q - 1'b1;
            end
            if (push) begin
                qdat_d[qtl_q] = imem_rsp_data;
                qpc_d[qtl_q]  = tag_q[thd_q];
                qtl_d         = qtl_q + 1'b1;
            end
            if (pop) begin
                qhd_d = qhd_q + 1'b1;
            end
            cnt_d = cnt_q + push_w - pop_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
            cnt_q   <= '0;
            qhd_q   <= '0;
            qtl_q   <= '0;
            thd_q   <= '0;
            ttl_q   <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                qdat_q[i] <= '0;
                qpc_q[i]  <= '0;
            end
            for (int i = 0; i < MAX_OUTST; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            qhd_q   <= qhd_d;
            qtl_q   <= qtl_d;
            thd_q   <= thd_d;
            ttl_q   <= ttl_d;
            qdat_q  <= qdat_d;
            qpc_q   <= qpc_d;
            tag_q   <= tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && imem_rsp_valid) begin
            assert (outst_q != '0);
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] bub_q, bub_d;

    always_comb begin
        bub_d = bub_q;
        if (ifid_write && !inst_valid_if && !redirect_valid
            && bub_q != 32'hFFFF_FFFF) begin
            bub_d = bub_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bub_q <= '0;
        end else begin
            bub_q <= bub_d;
        end
    end

    assign perf_bubble_cnt = bub_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order 1-cycle imem model
// and a program-order scoreboard for fetch addresses and consumed words.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        ifid_write;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] inst_if;
    logic [63:0] pcadd4_if;
    logic        inst_valid_if;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] bub_base;
`endif

    int n_tests;
    int n_fail;

    logic [63:0] pend[$];
    logic [63:0] exp_fetch;
    logic [63:0] exp_cons;
    logic        rsp_en;
    logic        fired;
    logic [63:0] fired_addr;

    if_fetch_unit #(
        .RESET_PC (64'h1000),
        .FQ_DEPTH (2),
        .MAX_OUTST(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .ifid_write    (ifid_write),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst_if       (inst_if),
        .pcadd4_if     (pcadd4_if),
        .inst_valid_if (inst_valid_if)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive imem response, check outputs, advance model.
    task automatic cyc();
        logic f;
        logic c;
        logic [63:0] a;
        imem_rsp_valid = rsp_en && pend.size() > 0;
        imem_rsp_data  = imem_rsp_valid ? memw(pend[0]) : 32'h0;
        #1;
        f = imem_req_valid && imem_req_ready;
        a = imem_req_addr;
        c = ifid_write && inst_valid_if && !redirect_valid;
        fired = f;
        fired_addr = a;
        if (f) chk("req_addr", a, exp_fetch);
        if (redirect_valid) chk("redir_noreq", imem_req_valid, 1'b0);
        if (inst_valid_if) begin
            chk("pcadd4", pcadd4_if, exp_cons + 64'd4);
            chk("inst", inst_if, memw(exp_cons));
        end else begin
            chk("bub_inst", inst_if, NOP);
            chk("bub_pc", pcadd4_if, 64'h0);
        end
        @(posedge clk);
        if (imem_rsp_valid) void'(pend.pop_front());
        if (f) pend.push_back(a);
        if (c) exp_cons += 64'd4;
        if (redirect_valid) begin
            exp_fetch = {redirect_pc[63:2], 2'b00};
            exp_cons  = {redirect_pc[63:2], 2'b00};
        end else if (f) begin
            exp_fetch += 64'd4;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int nf;
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;
        ifid_write = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        rsp_en = 1'b1;
        fired = 1'b0;
        fired_addr = 64'h0;
        exp_fetch = 64'h1000;
        exp_cons = 64'h1000;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_inst_valid", inst_valid_if, 1'b0);
        chk("rst_inst", inst_if, NOP);
        chk("rst_pcadd4", pcadd4_if, 64'h0);
`ifdef IF_PERF_CNT_EN
        chk("rst_perf", perf_bubble_cnt, 32'h0);
`endif
        rst = 1'b0;
        #1;
        chk("t1_first_valid", imem_req_valid, 1'b1);
        chk("t1_first_addr", imem_req_addr, 64'h1000);

        // 1: streaming fetch
        ifid_write = 1'b1;
        repeat (12) cyc();

        // 2: IF/ID stall fills the queue, then resume
        ifid_write = 1'b0;
        repeat (6) cyc();
        chk("t2_stall_noreq", imem_req_valid, 1'b0);
        chk("t2_stall_valid", inst_valid_if, 1'b1);
        ifid_write = 1'b1;
        repeat (8) cyc();

        // 3: redirect with two requests in flight
        imem_req_ready = 1'b0;
        repeat (5) cyc();
        chk("t3_drained", inst_valid_if, 1'b0);
        imem_req_ready = 1'b1;
        rsp_en = 1'b0;
        repeat (2) cyc();
        chk("t3_outst_full", imem_req_valid, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc = 64'h2002;
        cyc();
        redirect_valid = 1'b0;
        rsp_en = 1'b1;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!fired && k < 10);
        chk("t3_fire_seen", fired, 1'b1);
        chk("t3_fire_cycles", k, 3);
        chk("t3_first_addr", fired_addr, 64'h2000);
        k = 0;
        while (!inst_valid_if && k < 10) begin
            cyc();
            k++;
        end
        chk("t3_valid_seen", inst_valid_if, 1'b1);
        chk("t3_first_pc4", pcadd4_if, 64'h2004);
        repeat (4) cyc();

        // 4: redirect coinciding with a response and a pop
        k = 0;
        while (!(inst_valid_if && pend.size() > 0) && k < 10) begin
            cyc();
            k++;
        end
        chk("t4_setup", inst_valid_if && pend.size() > 0, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h3000;
        cyc();
        redirect_valid = 1'b0;
        chk("t4_empty", inst_valid_if, 1'b0);
        chk("t4_nop", inst_if, NOP);
        chk("t4_pc0", pcadd4_if, 64'h0);
        repeat (6) cyc();

        // 5: PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        nf = 0;
        k = 0;
        while (k < 12) begin
            if (inst_valid_if && pcadd4_if == 64'h0) break;
            cyc();
            if (fired) begin
                nf++;
                if (nf == 1) chk("t5_addr_top", fired_addr, 64'hFFFF_FFFF_FFFF_FFFC);
                if (nf == 2) chk("t5_addr_wrap", fired_addr, 64'h0);
            end
            k++;
        end
        chk("t5_wrap_word", inst_valid_if, 1'b1);
        chk("t5_wrap_pc4", pcadd4_if, 64'h0);
        chk("t5_wrap_inst", inst_if, memw(64'hFFFF_FFFF_FFFF_FFFC));
        repeat (6) cyc();

`ifdef IF_PERF_CNT_EN
        // 6: ten bubble cycles with imem not ready
        imem_req_ready = 1'b0;
        repeat (5) cyc();
        bub_base = perf_bubble_cnt;
        repeat (10) cyc();
        chk("t6_perf", perf_bubble_cnt, bub_base + 32'd10);
        imem_req_ready = 1'b1;
        repeat (4) cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
